// File: rtl/cmd_fifo_reader_if.sv
// cmd_fifo_reader_if: FIFO pin and valid/ready consumer bundle for cmd_fifo_reader
interface cmd_fifo_reader_if #(
  parameter int DW = 8,
  parameter int DEPTH = 4
);
  logic nef;
  logic fifo_rd_n;
  logic [DW-1:0] fifo_din;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  modport master (
    input nef, fifo_din, flush, out_ready,
    output fifo_rd_n, out_valid, out_data, level
  );
  modport slave (
    output nef, fifo_din, flush, out_ready,
    input fifo_rd_n, out_valid, out_data, level
  );
endinterface

// File: rtl/cmd_fifo_reader.sv
// cmd_fifo_reader: timed command FIFO reader with prefetch buffer; CMDRD_STATS_EN adds rd_count/drop_count
module cmd_fifo_reader #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  parameter int RD_WAIT = 2,
  parameter int RD_RECOVER = 1
) (
  input logic clk,
  input logic rst,
  cmd_fifo_reader_if.master bus
`ifdef CMDRD_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, STROBE, LATCH, RECOVER} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic drop, in_flight, start, push, pop;
  assign in_flight = state == STROBE || state == LATCH;
  assign start = state == IDLE && bus.nef && !bus.flush && (int'(level) + int'(in_flight)) < DEPTH;
  assign push = state == LATCH && !drop && !bus.flush;
  assign pop = bus.out_valid && bus.out_ready && !bus.flush;
  assign bus.fifo_rd_n = !in_flight;
  assign bus.out_valid = level != '0;
  assign bus.out_data = mem[rd_ptr];
  assign bus.level = level;
  // read-cycle state and timing counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 8'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // strobe/latch/recover sequencing
  always_comb begin
    state_nx = state;
    cnt_nx = 8'd0;
    case (state)
      IDLE: state_nx = start ? STROBE : IDLE;
      STROBE: if (cnt == 8'(RD_WAIT - 1)) state_nx = LATCH; else cnt_nx = cnt + 8'd1;
      LATCH: state_nx = RECOVER;
      RECOVER: if (cnt == 8'(RD_RECOVER - 1)) state_nx = IDLE; else cnt_nx = cnt + 8'd1;
      default: state_nx = IDLE;
    endcase
  end
  // buffer pointers and occupancy; a flush seen mid-read marks the in-flight byte for dropping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      drop <= 1'b0;
    end else begin
      drop <= start ? 1'b0 : drop | (bus.flush & in_flight);
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  // buffer storage, written with the FIFO bus value during LATCH
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.fifo_din;
  end
`ifdef CMDRD_STATS_EN
  // completed reads and bytes discarded by flush (buffered plus in-flight)
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      rd_count <= rd_count + 16'(state == LATCH);
      drop_count <= drop_count + (bus.flush ? 16'(level) : 16'd0) + 16'(state == LATCH && (drop || bus.flush));
    end
  end
`endif
endmodule

// File: tb/tb_cmd_fifo_reader.sv
// tb_cmd_fifo_reader: randomized bench for cmd_fifo_reader with FIFO-chip model and word scoreboard
module tb_cmd_fifo_reader;
  localparam int DW = 8, DEPTH = 4, RW = 2, RR = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cmd_fifo_reader_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
`ifdef CMDRD_STATS_EN
  logic [15:0] rd_count, drop_count;
`endif
  cmd_fifo_reader #(.DW(DW), .DEPTH(DEPTH), .RD_WAIT(RW), .RD_RECOVER(RR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CMDRD_STATS_EN
    ,
    .rd_count(rd_count),
    .drop_count(drop_count)
`endif
  );
  int checks = 0, errors = 0, cyc = 0, rd_idx = 0, n_src = 0, mx = 0, inv_err = 0;
  logic [DW-1:0] src [64];
  logic prev_rd_n = 1'b1;
  logic [DW-1:0] got_q[$], exp_q[$];
  int falls[$];
  task automatic add_word(input logic [DW-1:0] w, input bit keep);
    src[n_src] = w;
    n_src++;
    if (keep) exp_q.push_back(w);
  endtask
  task automatic step(input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    cyc++;
    if (prev_rd_n === 1'b1 && bus.fifo_rd_n === 1'b0) falls.push_back(cyc);
    if (prev_rd_n === 1'b0 && bus.fifo_rd_n === 1'b1 && rd_idx < n_src) rd_idx++;
    prev_rd_n = bus.fifo_rd_n;
    bus.nef = rd_idx < n_src;
    bus.fifo_din = src[rd_idx];
    bus.out_ready = rdy;
    bus.flush = fl;
    if (bus.out_valid === 1'b1 && rdy && !fl) got_q.push_back(bus.out_data);
    if (int'(bus.level) > mx) mx = int'(bus.level);
    if (bus.out_valid !== (bus.level != 0)) inv_err++;
  endtask
  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    falls.delete();
  endtask
  task automatic test_reset();
    add_word(8'hA5, 1'b1);
    bus.nef = 1'b1;
    bus.fifo_din = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (bus.fifo_rd_n !== 1'b1 || bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
        errors++;
        $display("FAIL reset cyc%0d rd_n=%b valid=%b level=%0d expected 1 0 0", i, bus.fifo_rd_n, bus.out_valid, bus.level);
      end
    end
    rst = 1'b0;
  endtask
  task automatic test_single_read();
    int low = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      if (bus.fifo_rd_n === 1'b0) low++;
      else if (low > 0) break;
    end
    checks++;
    if (low != RW + 1) begin
      errors++;
      $display("FAIL single_low_cycles got %0d expected %0d", low, RW + 1);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_word valid=%b data=%h expected 1 a5", bus.out_valid, bus.out_data);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (bus.level !== 3'd0 || got_q.size() != 1) begin
      errors++;
      $display("FAIL single_drain level=%0d popped=%0d expected 0 1", bus.level, got_q.size());
    end
  endtask
  task automatic test_fill();
    clear_sb();
    for (int i = 0; i < 6; i++) add_word(DW'($urandom), 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
    checks++;
    if (falls.size() != DEPTH || bus.level !== 3'(DEPTH) || bus.fifo_rd_n !== 1'b1) begin
      errors++;
      $display("FAIL fill strobes=%0d level=%0d rd_n=%b expected %0d %0d 1", falls.size(), bus.level, bus.fifo_rd_n, DEPTH, DEPTH);
    end
    for (int i = 0; i < 80; i++) step(1'b1, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fill_count got %0d expected %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fill_word%0d got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
  endtask
  task automatic test_concurrent();
    clear_sb();
    mx = 0;
    for (int i = 0; i < 10; i++) add_word(DW'(i), 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
    checks++;
    if (got_q.size() != 10) begin
      errors++;
      $display("FAIL conc_count got %0d expected 10", got_q.size());
    end else
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL conc_word%0d got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    checks++;
    if (mx > 1) begin
      errors++;
      $display("FAIL conc_max_level got %0d expected <=1", mx);
    end
    checks++;
    if (falls.size() != 10) begin
      errors++;
      $display("FAIL conc_strobes got %0d expected 10", falls.size());
    end
    for (int i = 1; i < falls.size(); i++) begin
      checks++;
      if (falls[i] - falls[i-1] != RW + RR + 2) begin
        errors++;
        $display("FAIL conc_spacing%0d got %0d expected %0d", i, falls[i] - falls[i-1], RW + RR + 2);
      end
    end
  endtask
  task automatic test_flush();
    bit found = 0, seen = 0;
    clear_sb();
    for (int i = 0; i < 3; i++) add_word(DW'($urandom), 1'b0);
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 1'b0);
      if (bus.level === 3'd2 && bus.fifo_rd_n === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL flush_setup got level=%0d expected 2 with strobe active", bus.level);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear level=%0d valid=%b expected 0 0", bus.level, bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen || rd_idx != n_src) begin
      errors++;
      $display("FAIL flush_drop valid_seen=%0d consumed=%0d expected 0 %0d", seen, rd_idx, n_src);
    end
`ifdef CMDRD_STATS_EN
    checks++;
    if (drop_count !== 16'd3) begin
      errors++;
      $display("FAIL flush_drop_count got %0d expected 3", drop_count);
    end
`endif
    add_word(DW'($urandom), 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL flush_resume count=%0d word=%h expected 1 %h", got_q.size(), got_q.size() ? got_q[0] : 8'h00, exp_q[0]);
    end
  endtask
  task automatic test_wrap();
    clear_sb();
    inv_err = 0;
    for (int i = 0; i < 20; i++) add_word(DW'($urandom), 1'b1);
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d expected %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_word%0d got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    checks++;
    if (inv_err != 0 || bus.level !== 3'd0) begin
      errors++;
      $display("FAIL wrap_valid_level violations=%0d level=%0d expected 0 0", inv_err, bus.level);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) src[i] = '0;
    bus.nef = 1'b0;
    bus.fifo_din = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_read();
    test_fill();
    test_concurrent();
    test_flush();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
